div_multi: RTL and testbench
============================

Name: div_multi

Overview:
- Multi-channel programmable clock divider; next generation of the single fixed-ratio divider.
- CH independent channels, each with runtime divide ratio and high-time (duty).
- Config updates are written over one shared valid/ready port and applied glitch-free at each channel's period boundary.
- Sits in the clocking/timing layer; feeds enables and strobes to the encoder datapath.

Parameters:
- CH, 4, number of divider channels (1..16).
- CNT_W, 8, width of counter, ratio and duty fields.
- NUM, 4, reset divide ratio for every channel.
- DUTY, 2, reset high-time (cycles) for every channel.
- CH_W, $clog2(CH) (min 1), width of cfg_ch; derived, not overridden.

Ports:
- clk_sig  in  1  single clock, rising edge.
- rst_sig  in  1  reset; asynchronous, active-high.
- en  in  CH  per-channel run enable.
- cfg_valid  in  1  config write request.
- cfg_ready  out  CH_W-independent 1  write accepted when valid&ready.
- cfg_ch  in  CH_W  target channel.
- cfg_num  in  CNT_W  new divide ratio.
- cfg_duty  in  CNT_W  new high-time.
- div_sig  out  CH  divided outputs, registered.
- tick  out  CH  1-cycle pulse on the first cycle of each period.
- upd_done  out  CH  1-cycle pulse when a pending config takes effect.

Behaviour:
- Per-channel state:
  - active regs num_a/duty_a (reset NUM/DUTY);
  - shadow regs num_s/duty_s;
  - pending flag;
  - counter cnt (reset 0);
  - started flag (reset 0).
- Reset (async, any time, incl. mid-period): cnt=0, started=0, pending=0, div_sig=0, tick=0, upd_done=0, active=NUM/DUTY.
- cfg_ready = ~pending[cfg_ch] (combinational); cfg_ch>=CH gives ready=1 and the write is dropped.
- Accepted write: shadow<=cfg_num/cfg_duty, pending<=1 on the next edge.
- Run (en=1, num_a>=2):
  - first edge with en=1 and started=0: cnt=0, started<=1, tick=1;
  - thereafter cnt increments and wraps num_a-1 -> 0; tick=1 in each cycle with cnt==0.
- div_sig is registered and always equals (cnt < duty_a) for the current cnt/duty_a, so the high phase is duty_a cycles of every num_a.
- Boundary (cnt==num_a-1 and pending):
  - next cycle: active<=shadow, cnt=0, pending<=0, upd_done=1;
  - div_sig/tick for the new period use the new values.
- Write accepted in the same cycle as a boundary: goes to shadow and is applied at the following boundary, not this one.
- Degenerate settings:
  - duty_a==0: div_sig constant 0.
  - duty_a>=num_a: div_sig constant 1.
  - num_a==1: tick every cycle; div_sig = (duty_a!=0).
  - num_a==0: channel stopped; cnt=0, div_sig=0, tick=0; a pending config applies on the next edge with upd_done.
- en=0:
  - cnt=0, started=0, div_sig=0, tick=0;
  - a pending config applies immediately on the next edge, upd_done=1.
  - Re-enable restarts cleanly with tick on the first enabled edge.
- Channels are fully independent except for the shared config port.

Optional Feature:
- Macro: DIV_SYNC_EN.
- Defined:
  - adds input sync_sig (1 bit);
  - a cycle with sync_sig=1 forces every enabled channel to apply any pending config (upd_done=1);
  - next cycle cnt=0, tick=1, so all channels are phase-aligned;
  - sync overrides a simultaneous natural boundary (single tick, single upd_done).
- Undefined: port absent; channels align only via reset/en.

Decomposition:
- Package div_pkg: default CNT_W, NUM, DUTY constants; typedef of the channel config struct {num, duty}.
- Sub-module div_chan: one channel (counter, active/shadow regs, pending, outputs).
- div_multi: owns the config decode/ready mux and instantiates CH div_chan via generate.

Test Plan:
- Reset default: release rst_sig, en=4'hF.
  - Required: every channel tick at edges 1,5,9; div_sig high 2 of every 4 cycles.
  - Outputs all 0 while rst_sig=1.
- Runtime update: write ch1 num=5 duty=3 mid-period.
  - Required: ch1 finishes the old 4-cycle period, then upd_done=1 and a 5-cycle period with 3 high.
  - Other channels unaffected.
- Backpressure: second write to ch1 while pending.
  - Required: cfg_ready=0; shadow keeps the first value.
  - After upd_done, ready=1 and the second write is accepted.
- Degenerate: ch2 duty=0 -> div_sig[2] stuck 0; ch3 duty=9 num=4 -> stuck 1; ch0 num=1 -> tick[0] every cycle.
- Enable/reset mid-op:
  - Drop en[1] with pending -> upd_done next edge, div_sig[1]=0; re-raise -> tick on the first edge.
  - Assert rst_sig async mid-high-phase -> div_sig drops immediately.
- DIV_SYNC_EN build: channels at differing phases, pulse sync_sig.
  - Required: all ticks coincide next cycle; pending configs applied with upd_done.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants, channel config type and helper for div_multi
//
// Purpose : default divider settings and the per-channel {num, duty} config
//           record used by div_chan for its active and shadow registers.
// Contents: DIV_CNT_W / DIV_NUM / DIV_DUTY defaults, CFG_W (widest supported
//           CNT_W), chan_cfg_t, make_cfg().
package div_pkg;

    localparam int DIV_CNT_W = 8;
    localparam int DIV_NUM   = 4;
    localparam int DIV_DUTY  = 2;

    // Config fields are stored at a fixed width so one struct type serves every
    // CNT_W up to 16; the unused upper bits are constant zero.
    localparam int CFG_W = 16;

    typedef struct packed {
        logic [CFG_W-1:0] num;
        logic [CFG_W-1:0] duty;
    } chan_cfg_t;

    function automatic chan_cfg_t make_cfg(input int num, input int duty);
        chan_cfg_t c;
        c.num  = CFG_W'(num);
        c.duty = CFG_W'(duty);
        return c;
    endfunction

endpackage

// File: rtl/div_chan.sv
// rtl/div_chan.sv - one programmable divider channel with shadowed config
//
// Purpose: counter with active/shadow ratio and high-time registers; a pending
//          shadow config is promoted at the period boundary, when stopped
//          (num==0), when disabled, or on a sync request.
// Ports  : i_clk, i_rst (async, active-high), i_en run enable, i_sync force
//          realign, i_wr accepted config write with i_num/i_duty,
//          o_pending shadow-valid flag, o_div/o_tick/o_upd_done registered outputs.
module div_chan
    import div_pkg::*;
#(
    parameter int CNT_W = DIV_CNT_W,
    parameter int NUM   = DIV_NUM,
    parameter int DUTY  = DIV_DUTY
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_num,
    input  logic [CNT_W-1:0] i_duty,
    output logic             o_pending,
    output logic             o_div,
    output logic             o_tick,
    output logic             o_upd_done
);

    chan_cfg_t        r_act;
    chan_cfg_t        r_shd;
    chan_cfg_t        w_act_n;
    logic             r_pending;
    logic             r_started;
    logic             r_div;
    logic             r_tick;
    logic             r_upd;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_apply;
    logic             w_run;
    logic             w_started_n;
    logic             w_tick_n;
    logic             w_div_n;
    logic [CFG_W-1:0] w_cnt_x;
    logic [CFG_W-1:0] w_last;

    assign w_cnt_x = CFG_W'(r_cnt);
    assign w_last  = r_act.num - CFG_W'(1);

    always_comb begin
        w_apply     = 1'b0;
        w_run       = 1'b0;
        w_started_n = 1'b0;
        w_tick_n    = 1'b0;
        w_cnt_n     = '0;
        if (!i_en || (r_act.num == '0)) begin
            // Idle: hold the counter cleared and let a pending config land now.
            w_apply = r_pending;
        end else if (i_sync || !r_started) begin
            // Realign or first enabled edge: new period starts here.
            w_apply     = r_pending & i_sync;
            w_run       = 1'b1;
            w_started_n = 1'b1;
            w_tick_n    = 1'b1;
        end else if (w_cnt_x >= w_last) begin
            // Natural period boundary; also covers num==1 (tick every cycle).
            w_apply     = r_pending;
            w_run       = 1'b1;
            w_started_n = 1'b1;
            w_tick_n    = 1'b1;
        end else begin
            w_cnt_n     = r_cnt + CNT_W'(1);
            w_run       = 1'b1;
            w_started_n = 1'b1;
        end
        w_act_n = w_apply ? r_shd : r_act;
        // Output is computed from the values the registers will hold, so the
        // first cycle of a new period already reflects the new config.
        w_div_n = w_run && (CFG_W'(w_cnt_n) < w_act_n.duty);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_act     <= make_cfg(NUM, DUTY);
            r_shd     <= make_cfg(NUM, DUTY);
            r_pending <= 1'b0;
            r_started <= 1'b0;
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_tick    <= 1'b0;
            r_upd     <= 1'b0;
        end else begin
            r_act <= w_act_n;
            // A write is only accepted while nothing is pending, so it never
            // collides with a promotion in the same cycle.
            if (i_wr) begin
                r_shd     <= make_cfg(int'(i_num), int'(i_duty));
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
            r_started <= w_started_n;
            r_cnt     <= w_cnt_n;
            r_div     <= w_div_n;
            r_tick    <= w_tick_n;
            r_upd     <= w_apply;
        end
    end

    assign o_pending  = r_pending;
    assign o_div      = r_div;
    assign o_tick     = r_tick;
    assign o_upd_done = r_upd;

endmodule

// File: rtl/div_multi.sv
// rtl/div_multi.sv - multi-channel programmable clock divider
//
// Purpose: CH independent divider channels sharing one valid/ready config port.
// Ports  : clk_sig, rst_sig (async, active-high), en[CH] run enables,
//          cfg_valid/cfg_ready/cfg_ch/cfg_num/cfg_duty config write,
//          div_sig[CH] divided outputs, tick[CH] period-start pulses,
//          upd_done[CH] config-applied pulses.
// Option : DIV_SYNC_EN adds input sync_sig, which restarts every enabled
//          channel and applies pending configs in the same cycle.
module div_multi
    import div_pkg::*;
#(
    parameter int  CH    = 4,
    parameter int  CNT_W = DIV_CNT_W,
    parameter int  NUM   = DIV_NUM,
    parameter int  DUTY  = DIV_DUTY,
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk_sig,
    input  logic             rst_sig,
`ifdef DIV_SYNC_EN
    input  logic             sync_sig,
`endif
    input  logic [CH-1:0]    en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_num,
    input  logic [CNT_W-1:0] cfg_duty,
    output logic [CH-1:0]    div_sig,
    output logic [CH-1:0]    tick,
    output logic [CH-1:0]    upd_done
);

    logic [CH-1:0] w_pending;
    logic [CH-1:0] w_wr;
    logic          w_sync;

`ifdef DIV_SYNC_EN
    assign w_sync = sync_sig;
`else
    assign w_sync = 1'b0;
`endif

    // Channel codes beyond CH match no channel: ready stays 1, write is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        w_wr      = '0;
        for (int i = 0; i < CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~w_pending[i];
                w_wr[i]   = cfg_valid & ~w_pending[i];
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_chan
        div_chan #(
            .CNT_W (CNT_W),
            .NUM   (NUM),
            .DUTY  (DUTY)
        ) u_chan (
            .i_clk      (clk_sig),
            .i_rst      (rst_sig),
            .i_en       (en[g]),
            .i_sync     (w_sync),
            .i_wr       (w_wr[g]),
            .i_num      (cfg_num),
            .i_duty     (cfg_duty),
            .o_pending  (w_pending[g]),
            .o_div      (div_sig[g]),
            .o_tick     (tick[g]),
            .o_upd_done (upd_done[g])
        );
    end

endmodule

// File: tb/tb_div_multi.sv
// tb/tb_div_multi.sv - self-checking bench for div_multi
module tb_div_multi;

    logic       clk_sig = 1'b0;
    logic       rst_sig = 1'b1;
`ifdef DIV_SYNC_EN
    logic       sync_sig = 1'b0;
`endif
    logic [3:0] en = 4'hF;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_ch = 2'd0;
    logic [7:0] cfg_num = 8'd0;
    logic [7:0] cfg_duty = 8'd0;
    logic [3:0] div_sig;
    logic [3:0] tick;
    logic [3:0] upd_done;

    int checks = 0;
    int failures = 0;

    div_multi #(.CH(4), .CNT_W(8), .NUM(4), .DUTY(2)) dut (
        .clk_sig   (clk_sig),
        .rst_sig   (rst_sig),
`ifdef DIV_SYNC_EN
        .sync_sig  (sync_sig),
`endif
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_num   (cfg_num),
        .cfg_duty  (cfg_duty),
        .div_sig   (div_sig),
        .tick      (tick),
        .upd_done  (upd_done)
    );

    always #5 clk_sig = ~clk_sig;

    typedef struct {
        logic [3:0] en;
        logic       valid;
        logic [1:0] ch;
        logic [7:0] num;
        logic [7:0] duty;
        logic       rdy;
        logic [3:0] div;
        logic [3:0] tck;
        logic [3:0] upd;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [3:0] e, input logic v, input logic [1:0] c,
                       input logic [7:0] n, input logic [7:0] d, input logic r,
                       input logic [3:0] dv, input logic [3:0] tk, input logic [3:0] up);
        vec_t x;
        x.en = e; x.valid = v; x.ch = c; x.num = n; x.duty = d;
        x.rdy = r; x.div = dv; x.tck = tk; x.upd = up;
        tv.push_back(x);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sig);
        @(negedge clk_sig);
    endtask

    initial begin
        // Row n describes inputs applied before edge n after reset release and
        // the outputs expected after that edge.
        //    en    vld ch num duty rdy div   tick  upd
        add(4'hF, 0, 0, 0, 0, 0, 4'hF, 4'hF, 4'h0);  // 1  all start, cnt 0
        add(4'hF, 0, 0, 0, 0, 0, 4'hF, 4'h0, 4'h0);  // 2
        add(4'hF, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);  // 3
        add(4'hF, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);  // 4
        add(4'hF, 0, 0, 0, 0, 0, 4'hF, 4'hF, 4'h0);  // 5  second period
        add(4'hF, 1, 1, 5, 3, 1, 4'hF, 4'h0, 4'h0);  // 6  ch1 <- 5/3
        add(4'hF, 1, 1, 7, 1, 0, 4'h0, 4'h0, 4'h0);  // 7  blocked while pending
        add(4'hF, 1, 1, 7, 1, 0, 4'h0, 4'h0, 4'h0);  // 8
        add(4'hF, 1, 1, 7, 1, 0, 4'hF, 4'hF, 4'h2);  // 9  ch1 applies 5/3
        add(4'hF, 1, 1, 7, 1, 1, 4'hF, 4'h0, 4'h0);  // 10 ch1 <- 7/1 accepted
        add(4'hF, 0, 0, 0, 0, 0, 4'h2, 4'h0, 4'h0);  // 11
        add(4'hF, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0);  // 12
        add(4'hF, 0, 0, 0, 0, 0, 4'hD, 4'hD, 4'h0);  // 13 ch1 still in 5-period
        add(4'hF, 0, 0, 0, 0, 0, 4'hF, 4'h2, 4'h2);  // 14 ch1 applies 7/1
        add(4'hF, 1, 2, 4, 0, 1, 4'h0, 4'h0, 4'h0);  // 15 ch2 duty 0
        add(4'hF, 1, 3, 4, 9, 1, 4'h0, 4'h0, 4'h0);  // 16 ch3 duty > num
        add(4'hF, 1, 0, 1, 1, 1, 4'h9, 4'hD, 4'hC);  // 17 ch0 num 1; ch2/ch3 apply
        add(4'hF, 0, 0, 0, 0, 0, 4'h9, 4'h0, 4'h0);  // 18
        add(4'hF, 0, 0, 0, 0, 0, 4'h8, 4'h0, 4'h0);  // 19
        add(4'hF, 0, 0, 0, 0, 0, 4'h8, 4'h0, 4'h0);  // 20
        add(4'hF, 0, 0, 0, 0, 0, 4'hB, 4'hF, 4'h1);  // 21 ch0 applies num 1
        add(4'hF, 1, 1, 4, 2, 1, 4'h9, 4'h1, 4'h0);  // 22 ch1 <- 4/2
        add(4'hF, 0, 0, 0, 0, 0, 4'h9, 4'h1, 4'h0);  // 23
        add(4'hD, 0, 0, 0, 0, 0, 4'h9, 4'h1, 4'h2);  // 24 en[1]=0 applies pending
        add(4'hD, 0, 0, 0, 0, 0, 4'h9, 4'hD, 4'h0);  // 25
        add(4'hF, 0, 0, 0, 0, 0, 4'hB, 4'h3, 4'h0);  // 26 ch1 restarts with tick
        add(4'hF, 0, 0, 0, 0, 0, 4'hB, 4'h1, 4'h0);  // 27

        // Outputs idle while held in reset.
        repeat (3) @(posedge clk_sig);
        @(negedge clk_sig);
        chk("rst_div", 8'(div_sig), 8'h0);
        chk("rst_tick", 8'(tick), 8'h0);
        chk("rst_upd", 8'(upd_done), 8'h0);
        chk("rst_ready", 8'(cfg_ready), 8'h1);
        rst_sig = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            en        = tv[i].en;
            cfg_valid = tv[i].valid;
            cfg_ch    = tv[i].ch;
            cfg_num   = tv[i].num;
            cfg_duty  = tv[i].duty;
            #1;
            if (tv[i].valid)
                chk($sformatf("row%0d_ready", i + 1), 8'(cfg_ready), 8'(tv[i].rdy));
            step();
            chk($sformatf("row%0d_div", i + 1), 8'(div_sig), 8'(tv[i].div));
            chk($sformatf("row%0d_tick", i + 1), 8'(tick), 8'(tv[i].tck));
            chk($sformatf("row%0d_upd", i + 1), 8'(upd_done), 8'(tv[i].upd));
        end
        cfg_valid = 1'b0;

        // Asynchronous reset between edges while several outputs are high.
        #2 rst_sig = 1'b1;
        #1;
        chk("async_rst_div", 8'(div_sig), 8'h0);
        chk("async_rst_tick", 8'(tick), 8'h0);
        @(negedge clk_sig);
        rst_sig = 1'b0;
        en = 4'hF;
        step();
        chk("restart_tick", 8'(tick), 8'hF);
        chk("restart_div", 8'(div_sig), 8'hF);
        chk("restart_upd", 8'(upd_done), 8'h0);
        step();
        chk("restart_tick2", 8'(tick), 8'h0);

`ifdef DIV_SYNC_EN
        // Put ch1 out of phase, queue a config on ch2, then force alignment.
        en = 4'hD;
        step();
        en = 4'hF;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_num = 8'd3; cfg_duty = 8'd1;
        #1;
        chk("sync_wr_ready", 8'(cfg_ready), 8'h1);
        step();
        chk("sync_pre_tick", 8'(tick), 8'h2);
        cfg_valid = 1'b0;
        sync_sig = 1'b1;
        step();
        sync_sig = 1'b0;
        chk("sync_tick", 8'(tick), 8'hF);
        chk("sync_upd", 8'(upd_done), 8'h4);
        chk("sync_div", 8'(div_sig), 8'hF);
        step();
        chk("sync_post_tick", 8'(tick), 8'h0);
        chk("sync_post_div", 8'(div_sig), 8'hB);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
